// File: rtl/alu_seq.sv
// Multi-cycle ALU: start/done handshake, registered result and flags, iterative SHL.
// Define ALU_MUL_EN to build the shift-add multiplier for opcode 7.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [2:0]       ALU_OP,
  output logic [WIDTH-1:0] result,
  output logic             SKZ_cmp,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
`ifdef ALU_MUL_EN
  localparam int MW  = 2 * WIDTH;
`else
  localparam int MW  = WIDTH;
`endif

  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    mc_q, mc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               mul_q, mul_d;
`endif

  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] res_c, step_res;
  logic             car_c, step_car;

  assign sum = {1'b0, inA} + {1'b0, inB};
  assign dif = {1'b0, inA} - {1'b0, inB};
  assign n   = inB[SHW-1:0];

  always_comb begin
    res_c = '0;
    car_c = 1'b0;
    unique case (ALU_OP)
      OP_PASSA: res_c = inA;
      OP_ADD:   {car_c, res_c} = sum;
      OP_SUB:   {car_c, res_c} = dif;
      OP_AND:   res_c = inA & inB;
      OP_XOR:   res_c = inA ^ inB;
      OP_PASSB: res_c = inB;
      OP_SHL:   res_c = inA;
      OP_MUL:   res_c = '0;
      default:  res_c = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_d     = mc_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    step_res = '0;
    step_car = 1'b0;
`ifdef ALU_MUL_EN
    acc_d  = acc_q;
    mb_d   = mb_q;
    mul_d  = mul_q;
    acc_nx = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (ALU_OP == OP_SHL && n != '0) begin
            state_d = RUN;
            mc_d    = MW'(inA);
            cnt_d   = {1'b0, n};
`ifdef ALU_MUL_EN
            mul_d   = 1'b0;
          end else if (ALU_OP == OP_MUL) begin
            state_d = RUN;
            mc_d    = MW'(inA);
            mb_d    = inB;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            mul_d   = 1'b1;
`endif
          end else begin
            result_d = res_c;
            carry_d  = car_c;
            zero_d   = (res_c == '0);
            done_d   = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        mc_d  = mc_q << 1;
`ifdef ALU_MUL_EN
        if (mul_q) begin
          acc_nx   = acc_q + (mb_q[0] ? mc_q : '0);
          acc_d    = acc_nx;
          mb_d     = mb_q >> 1;
          step_res = acc_nx[WIDTH-1:0];
          step_car = |acc_nx[2*WIDTH-1:WIDTH];
        end else
`endif
        begin
          // carry is the bit leaving position WIDTH-1 on this step
          step_res = mc_d[WIDTH-1:0];
          step_car = mc_q[WIDTH-1];
        end
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          result_d = step_res;
          carry_d  = step_car;
          zero_d   = (step_res == '0);
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mc_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mb_q     <= '0;
      mul_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_q     <= mc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mb_q     <= mb_d;
      mul_q    <= mul_d;
`endif
    end
  end

  assign result  = result_q;
  assign SKZ_cmp = zero_q;
  assign carry   = carry_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed table, hand sequences, random ops vs model.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] inA, inB;
  logic [2:0] ALU_OP;
  logic [7:0] result;
  logic       SKZ_cmp, carry, busy, done;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
    .ALU_OP(ALU_OP), .result(result), .SKZ_cmp(SKZ_cmp),
    .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       car;
    logic       zero;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference computed from the opcode definitions with integer arithmetic
  task automatic model(input int op, input int a, input int b,
                       output int res, output int car, output int lat);
    int nsh, p;
    res = 0; car = 0; lat = 1;
    case (op)
      0: res = a;
      1: begin p = a + b; res = p % 256; car = (p > 255); end
      2: begin res = (a - b + 256) % 256; car = (a < b); end
      3: res = a & b;
      4: res = a ^ b;
      5: res = b;
      6: begin
        nsh = b % 8;
        res = (a << nsh) & 255;
        car = (nsh == 0) ? 0 : ((a >> (8 - nsh)) & 1);
        lat = nsh + 1;
      end
      default: begin
        if (MUL_EN) begin
          p = a * b;
          res = p % 256;
          car = (p / 256) != 0;
          lat = 9;
        end
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    ALU_OP = op; inA = a; inB = b; start = 1'b1;
  endtask

  // Runs from the start cycle until done; optional ADD pulse at cycle inj
  task automatic wait_done(input string tag, input int exp_lat,
                           input int inj, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == inj) begin
        start = 1'b1; ALU_OP = 3'd1;
        inA = 8'h01; inB = 8'h01;
      end else begin
        start = 1'b0;
        inA = 8'($urandom); inB = 8'($urandom);
        ALU_OP = 3'($urandom);
      end
      if (lat < exp_lat) chk({tag, " busy"}, busy, 1);
    end while (!done && lat < 40);
    chk({tag, " busy_in_done"}, busy, 0);
  endtask

  task automatic check_out(input string tag, input int lat, input int exp_lat,
                           input int res, input int car);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " done"}, done, 1);
    chk({tag, " result"}, result, res);
    chk({tag, " carry"}, carry, car);
    chk({tag, " zero"}, SKZ_cmp, (res == 0) ? 1 : 0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    int er, ec, el, lat;
    model(op, a, b, er, ec, el);
    @(negedge clk);
    issue(op, a, b);
    wait_done(tag, el, -1, lat);
    check_out(tag, lat, el, er, ec);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, er, ec, el, saw_done;
    rst = 1'b1; start = 1'b0; inA = '0; inB = '0; ALU_OP = '0;

    vecs.push_back('{3'd0, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1});
    vecs.push_back('{3'd2, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd2, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1});
    vecs.push_back('{3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd4, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd5, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{3'd6, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4});
    vecs.push_back('{3'd6, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 2});
    vecs.push_back('{3'd6, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1});
    vecs.push_back('{3'd6, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 8});
    if (MUL_EN) begin
      vecs.push_back('{3'd7, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 9});
      vecs.push_back('{3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 9});
      vecs.push_back('{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 9});
    end else begin
      vecs.push_back('{3'd7, 8'h0F, 8'h11, 8'h00, 1'b0, 1'b1, 1});
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset result", result, 0);
    chk("reset zero", SKZ_cmp, 1);
    chk("reset carry", carry, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, -1, lat);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d carry", i), carry, vecs[i].car);
      chk($sformatf("vec%0d zero", i), SKZ_cmp, vecs[i].zero);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done_pulse", i), done, 0);
    end

    // Back-to-back: second SUB issued while done of the first is high
    @(negedge clk);
    issue(3'd2, 8'h05, 8'h05);
    wait_done("b2b1", 1, -1, lat);
    check_out("b2b1", lat, 1, 0, 0);
    issue(3'd2, 8'h03, 8'h05);
    wait_done("b2b2", 1, -1, lat);
    check_out("b2b2", lat, 1, 8'hFE, 1);

    // Start pulse during a multi-cycle op must be ignored
    do_op("pre_ign", 3'd1, 8'h20, 8'h30);
    @(negedge clk);
    if (MUL_EN) begin
      issue(3'd7, 8'h0F, 8'h11);
      wait_done("ign", 9, 3, lat);
      check_out("ign", lat, 9, 8'hFF, 0);
    end else begin
      issue(3'd6, 8'h81, 8'h03);
      wait_done("ign", 4, 3, lat);
      check_out("ign", lat, 4, 8'h08, 0);
    end
    @(posedge clk); #1;
    chk("ign no_extra_done", done, 0);

    // Asynchronous abort at cycle 4 of a long op
    do_op("pre_rst", 3'd0, 8'hA5, 8'h00);
    @(negedge clk);
    if (MUL_EN) issue(3'd7, 8'h0F, 8'h11);
    else        issue(3'd6, 8'hFF, 8'h07);
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("abort result", result, 0);
    chk("abort zero", SKZ_cmp, 1);
    chk("abort carry", carry, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    saw_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    chk("abort no_done", saw_done, 0);
    @(negedge clk); rst = 1'b0;
    issue(3'd1, 8'h01, 8'h01);
    wait_done("post_rst", 1, -1, lat);
    check_out("post_rst", lat, 1, 8'h02, 0);

    // Random ops against the model, some back-to-back
    for (int k = 0; k < 300; k++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      model(op, a, b, er, ec, el);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(op, a, b);
      wait_done($sformatf("rnd%0d", k), el, -1, lat);
      check_out($sformatf("rnd%0d", k), lat, el, er, ec);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the CPU datapath, successor to the 8-bit combinational ALU. It adds a start/done handshake, registered result and flags, an iterative barrel-free left shift, and an optional shift-add multiplier. It sits between the accumulator/operand registers and the controller. The controller issues `start` and waits for `done` before latching `result` or testing `SKZ_cmp`.

## Interface
- `WIDTH`, 8: operand/result width. Power of two, at least 4. Derived localparam `SHW = $clog2(WIDTH)`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only while idle.
- `inA` input WIDTH: operand A; sampled on the accepting edge.
- `inB` input WIDTH: operand B; sampled on the accepting edge.
- `ALU_OP` input 3: opcode; sampled on the accepting edge.
- `result` output WIDTH: registered result; held until the next completion.
- `SKZ_cmp` output 1: registered zero flag, `result == 0`.
- `carry` output 1: registered carry/borrow/overflow flag.
- `busy` output 1: multi-cycle operation in progress.
- `done` output 1: one-cycle pulse; `result` and flags are valid and new.

## Operation
- Opcodes and their flags:
  - 0 PASSA: result = A; carry = 0.
  - 1 ADD: result = A+B mod 2^WIDTH; carry = carry-out.
  - 2 SUB: result = A−B mod 2^WIDTH; carry = borrow (A<B unsigned).
  - 3 AND: carry = 0.
  - 4 XOR: carry = 0.
  - 5 PASSB: result = B; carry = 0.
  - 6 SHL: result = A << n, where n = B[SHW-1:0], one bit per cycle. carry = last bit shifted out, or 0 if n=0.
  - 7 MUL: low WIDTH bits of unsigned A*B via shift-add with a 2·WIDTH accumulator. carry = 1 if the high WIDTH bits are non-zero.
- FSM states:
  - IDLE → RUN on `start` with SHL n≠0 or MUL. Load operands and the counter (n, or WIDTH).
  - IDLE stays IDLE on `start` with any other opcode, or SHL n=0. Result, flags and `done` are written on the same edge.
  - RUN: one step per edge, counter decrements. On the edge where the counter reaches its final step, write result and flags, pulse `done`, and return to IDLE.
- `SKZ_cmp` and `carry` update only on completion, together with `result`.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the cycle `done`=1 is accepted, since the FSM is already IDLE. This allows back-to-back ops.
- Operand inputs may change freely after the accepting edge.

## Timing
- Latency is measured from the `start` cycle to the cycle where `done`=1:
  - ops 0–5, and SHL with n=0: 1.
  - SHL: n+1.
  - MUL: WIDTH+1.
- `busy`=1 from the cycle after acceptance through the last RUN cycle. It is 0 in the `done` cycle.
- Maximum throughput is one single-cycle op per clock.
- Reset values: `result`=0, `SKZ_cmp`=1, `carry`=0, `busy`=0, `done`=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously. No `done` is issued for the aborted op. The first edge after deassertion may accept `start`.

## Configuration
- `ALU_MUL_EN` defined: opcode 7 is the shift-add multiplier described above.
- `ALU_MUL_EN` undefined: no multiplier logic. Opcode 7 completes with latency 1, result=0, `carry`=0, `SKZ_cmp`=1.

## Test plan
All scenarios use WIDTH=8.
- ADD A=0xF0, B=0x20 → `done` next cycle; result=0x10, carry=1, SKZ_cmp=0.
- SUB 0x05−0x05 → result=0x00, SKZ_cmp=1, carry=0. Then SUB 0x03−0x05 back-to-back, `start` held in the `done` cycle → result=0xFE, carry=1.
- SHL A=0x81, B=0x03 → busy for 3 cycles, `done` 4 cycles after `start`; result=0x08, carry=0. SHL A=0x81, B=0x01 → result=0x02, carry=1. SHL B=0x08 (n=0) → latency 1, result=0x81.
- MUL (`ALU_MUL_EN` defined) 0x0F×0x11 → `done` 9 cycles after `start`; result=0xFF, carry=0. MUL 0x10×0x10 → result=0x00, carry=1, SKZ_cmp=1. Pulse `start` with ADD at cycle 3 of a MUL → ignored, MUL result unchanged.
- Reset at cycle 4 of a MUL → all outputs take reset values immediately, no `done`. ADD 0x01+0x01 right after deassertion → result=0x02.
- `ALU_MUL_EN` undefined: MUL 0x0F×0x11 → `done` next cycle; result=0x00, SKZ_cmp=1, carry=0.
